// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD sequencer.
// The init ROM holds the power-on command bytes in issue order.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_SETUP,
        INIT_PULSE,
        INIT_HOLD,
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } lcd_state_t;

    localparam logic [7:0] FUNC_SET_8B_2L = 8'h38;
    localparam logic [7:0] DISP_ON        = 8'h0C;
    localparam logic [7:0] CLEAR          = 8'h01;
    localparam logic [7:0] ENTRY_INC      = 8'h06;

    localparam int LCD_INIT_LEN = 4;

    localparam logic [7:0] LCD_INIT_ROM [LCD_INIT_LEN] = '{
        FUNC_SET_8B_2L,
        DISP_ON,
        CLEAR,
        ENTRY_INC
    };

endpackage

// File: rtl/lcd_cmd_sequencer_tick_gen.sv
// Free-running divider; tick is high in the last count before wrap,
// so logic clocked by clk acts on the wrap edge itself.
module tick_gen #(
    parameter int TICK_DIV_BITS = 17
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [TICK_DIV_BITS-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + TICK_DIV_BITS'(1);
        end
    end

    assign tick = &count;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Write-only 8-bit LCD controller: power-up wait, init ROM replay,
// then one setup/enable/hold window per accepted byte.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int TICK_DIV_BITS = 17,
    parameter int PWRUP_TICKS   = 8,
    parameter int INIT_LEN      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db
);

    localparam int PW_W  = $clog2(PWRUP_TICKS + 1);
    localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

    localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PWRUP_TICKS - 1);
    localparam logic [PW_W-1:0]  PW_SAT   = PW_W'(PWRUP_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);

    logic             tick;
    lcd_state_t       state;
    logic [PW_W-1:0]  pwr_cnt;
    logic [IDX_W-1:0] idx;

    tick_gen #(
        .TICK_DIV_BITS(TICK_DIV_BITS)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // lcd_db/lcd_rs double as the request latch; they only change
    // when a new window opens, so they stay stable across it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWRUP;
            pwr_cnt   <= '0;
            idx       <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_db    <= '0;
        end else begin
            lcd_rw <= 1'b0;
            unique case (state)
                PWRUP: begin
                    if (tick && pwr_cnt != PW_SAT) begin
                        pwr_cnt <= pwr_cnt + PW_W'(1);
                        if (pwr_cnt == PW_LAST) begin
                            state  <= INIT_SETUP;
                            idx    <= '0;
                            lcd_e  <= 1'b0;
                            lcd_rs <= 1'b0;
                            lcd_db <= LCD_INIT_ROM[0];
                        end
                    end
                end
                INIT_SETUP: begin
                    if (tick) begin
                        state <= INIT_PULSE;
                        lcd_e <= 1'b1;
                    end
                end
                INIT_PULSE: begin
                    if (tick) begin
                        state <= INIT_HOLD;
                        lcd_e <= 1'b0;
                    end
                end
                INIT_HOLD: begin
                    if (tick) begin
                        if (idx == IDX_LAST) begin
                            state     <= IDLE;
                            init_done <= 1'b1;
                            req_ready <= 1'b1;
                        end else begin
                            state  <= INIT_SETUP;
                            idx    <= idx + IDX_W'(1);
                            lcd_db <= LCD_INIT_ROM[idx + IDX_W'(1)];
                        end
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                        lcd_rs    <= req_rs;
                        lcd_db    <= req_data;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state <= PULSE;
                        lcd_e <= 1'b1;
                    end
                end
                PULSE: begin
                    if (tick) begin
                        state <= HOLD;
                        lcd_e <= 1'b0;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer with a 16-clk tick; a scoreboard queue
// holds the bytes expected on each lcd_e strobe.
module tb_lcd_cmd_sequencer;

    localparam int TP = 16;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         phase;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;

    int errors = 0;
    int checks = 0;
    int rel_cyc = 0;
    int hs_count = 0;
    int hs_cyc = 0;
    logic [8:0] exp_q[$];

    logic       prev_e = 1'b0;
    logic       prev_done = 1'b0;
    int         rise_cyc = 0;
    logic [8:0] rise_val = 9'h0;

    vec_t vecs[6];

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .TICK_DIV_BITS(4),
        .PWRUP_TICKS  (8),
        .INIT_LEN     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_db   (lcd_db)
    );

    task automatic check(string name, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected want event", name);
    endtask

    task automatic push_rom();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic wait_hs(int n, int limit);
        int k = 0;
        while (hs_count < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (hs_count < n) fail("hs_timeout");
    endtask

    task automatic wait_ready(int limit);
        int k = 0;
        while (!req_ready && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) fail("ready_timeout");
    endtask

    task automatic send_vec(vec_t v);
        int k = 0;
        int h;
        while (!(req_ready && ((rel_cyc + 1) % TP) == v.phase)
               && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) fail("vec_ready_timeout");
        req_valid = 1'b1;
        req_rs    = v.rs;
        req_data  = v.data;
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_drop", req_ready, 0);
        check("hs_phase", hs_cyc % TP, v.phase);
        h = hs_cyc;
        wait_ready(100);
        check("ready_lat", rel_cyc - h, v.lat);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            rel_cyc <= 0;
        end else begin
            rel_cyc <= rel_cyc + 1;
        end
        if (!rst && req_valid && req_ready) begin
            exp_q.push_back({req_rs, req_data});
            hs_count <= hs_count + 1;
            hs_cyc   <= rel_cyc + 1;
        end
    end

    // Strobe monitor: byte order, alignment, width, bus stability.
    always @(negedge clk) begin
        check("rw_zero", lcd_rw, 0);
        if (rst) begin
            prev_e    <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            if (!init_done) check("ready_pre_init", req_ready, 0);
            if (lcd_e) check("ready_during_e", req_ready, 0);
            if (lcd_e && !prev_e) begin
                check("e_align", rel_cyc % TP, 0);
                rise_cyc <= rel_cyc;
                rise_val <= {lcd_rs, lcd_db};
                if (exp_q.size() == 0) fail("e_unexpected");
                else check("byte", {lcd_rs, lcd_db}, exp_q.pop_front());
            end else if (lcd_e) begin
                check("db_stable", {lcd_rs, lcd_db}, rise_val);
            end else if (prev_e) begin
                check("e_width", rel_cyc - rise_cyc, TP);
            end
            if (init_done && !prev_done) begin
                check("done_at", rel_cyc, 20 * TP);
            end
            prev_e    <= lcd_e;
            prev_done <= init_done;
        end
    end

    initial begin
        int n;
        int h1;
        int k;
        vecs[0] = '{1'b1, 8'h41, 3, 45};
        vecs[1] = '{1'b0, 8'h80, 0, 48};
        vecs[2] = '{1'b1, 8'h42, 15, 33};
        vecs[3] = '{1'b0, 8'h01, 1, 47};
        vecs[4] = '{1'b1, 8'h7E, 8, 40};
        vecs[5] = '{1'b0, 8'hC0, 12, 36};

        repeat (3) @(negedge clk);
        check("rst_outs",
              {req_ready, init_done, lcd_e, lcd_rs, lcd_rw, lcd_db}, 0);
        push_rom();
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h55;
        rst = 1'b0;

        wait_hs(1, 400);
        check("early_hs_cyc", hs_cyc, 20 * TP + 1);
        req_valid = 1'b0;
        wait_ready(100);

        for (int i = 0; i < 6; i++) begin
            send_vec(vecs[i]);
        end

        wait_ready(100);
        n = hs_count;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        @(negedge clk);
        check("held_first", hs_count, n + 1);
        h1 = hs_cyc;
        req_data = 8'h42;
        wait_hs(n + 2, 200);
        req_valid = 1'b0;
        check("held_gap", hs_cyc - h1, 48);
        @(negedge clk);
        check("held_once", hs_count, n + 2);
        wait_ready(100);

        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h01;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!lcd_e && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!lcd_e) fail("e_wait_timeout");
        rst = 1'b1;
        @(negedge clk);
        check("rst_e", lcd_e, 0);
        check("rst_done", init_done, 0);
        check("rst_ready", req_ready, 0);
        exp_q.delete();
        push_rom();
        rst = 1'b0;
        k = 0;
        while (!init_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!init_done) fail("reinit_timeout");
        wait_ready(10);
        send_vec('{1'b1, 8'h33, 0, 48});
        repeat (40) @(negedge clk);
        check("q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
